// File: rtl/gt_drp_arbiter.sv
// ----------------------------------------------------------------------------
// gt_drp_arbiter
//
// Shares one GTX channel DRP port between NUM_REQ requesters (reset FSM,
// eye-scan engine, host register bridge, ...). The arbiter runs on the stable
// system clock that also drives drpclk. It grants requesters round-robin,
// keeps exactly one DRP transaction in flight, and aborts a transaction whose
// drprdy never arrives after TIMEOUT_CYCLES cycles so the port cannot hang.
//
// Optional feature: define GT_DRP_RMW_EN to add req_mask_i and turn masked
// writes into read-modify-write sequences (read, merge, write). Without the
// macro every write is full-word and there is no MERGE state.
//
// Ports:
//   sys_clk_i    system clock, also the DRP clock
//   sys_rst_n_i  asynchronous active-low reset
//   req_valid_i  per-requester request, held until req_ready_o
//   req_we_i     per-requester write enable (1 = write, 0 = read)
//   req_addr_i   packed per-requester DRP address (slice i = requester i)
//   req_wdata_i  packed per-requester write data (slice i = requester i)
//   req_mask_i   (GT_DRP_RMW_EN only) packed write mask, 1 = take wdata bit
//   req_ready_o  one-cycle accept pulse to the granted requester
//   rsp_valid_o  one-cycle completion pulse to the granted requester
//   rsp_rdata_o  read data, meaningful while any rsp_valid_o bit is high
//   rsp_err_o    timeout flag, qualified by rsp_valid_o
//   busy_o       high whenever a transaction is in progress
//   drpen_o, drpwe_o, drpaddr_o, drpdi_o, drpdo_i, drprdy_i  DRP port
// ----------------------------------------------------------------------------
module gt_drp_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
`ifdef GT_DRP_RMW_EN
  input  logic [NUM_REQ*DATA_W-1:0] req_mask_i,
`endif
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      drpen_o,
  output logic                      drpwe_o,
  output logic [ADDR_W-1:0]         drpaddr_o,
  output logic [DATA_W-1:0]         drpdi_o,
  input  logic [DATA_W-1:0]         drpdo_i,
  input  logic                      drprdy_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
`ifdef GT_DRP_RMW_EN
    MERGE = 3'd4,
`endif
    RESP  = 3'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic               we_lat;
  logic [ADDR_W-1:0]  addr_lat;
  logic [DATA_W-1:0]  di_lat;
  logic [DATA_W-1:0]  cap_data;
  logic               err;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   rr_next;

`ifdef GT_DRP_RMW_EN
  logic [DATA_W-1:0]  mask_lat;
  logic               rmw;      // latched write needs the read-merge-write path
  logic               phase2;   // set once the merged write has been prepared
  logic               rmw_rd;   // currently running the read half of an RMW
  logic [DATA_W-1:0]  pick_mask;

  assign pick_mask = req_mask_i[int'(pick)*DATA_W +: DATA_W];
  assign rmw_rd    = rmw & ~phase2;
`endif

  // Round-robin search starting at rr_ptr. The loop walks offsets from the
  // far end down so the lowest offset with a valid request is assigned last.
  always_comb begin
    int j;
    pick    = '0;
    any_req = 1'b0;
    j       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid_i[IDX_W'(j)]) begin
        pick    = IDX_W'(j);
        any_req = 1'b1;
      end
    end
  end

  assign gnt_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
  assign rr_next = (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

  // State register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) state <= IDLE;
    else              state <= state_next;
  end

  // Next-state logic; drprdy_i is only looked at in WAIT, so stray ready
  // pulses in any other state fall on the floor.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (drprdy_i) begin
`ifdef GT_DRP_RMW_EN
          state_next = rmw_rd ? MERGE : RESP;
`else
          state_next = RESP;
`endif
        end else if (cnt == CNT_LAST) begin
          state_next = RESP;
        end
      end
`ifdef GT_DRP_RMW_EN
      MERGE:   state_next = ISSUE;
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latched request, timeout counter, captured response and rr pointer.
  // Everything here feeds an output, so it is all cleared by reset.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rr_ptr   <= '0;
      gnt      <= '0;
      we_lat   <= 1'b0;
      addr_lat <= '0;
      di_lat   <= '0;
      cap_data <= '0;
      err      <= 1'b0;
      cnt      <= '0;
`ifdef GT_DRP_RMW_EN
      mask_lat <= '0;
      rmw      <= 1'b0;
      phase2   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt      <= pick;
            we_lat   <= req_we_i[pick];
            addr_lat <= req_addr_i[int'(pick)*ADDR_W +: ADDR_W];
            di_lat   <= req_wdata_i[int'(pick)*DATA_W +: DATA_W];
`ifdef GT_DRP_RMW_EN
            mask_lat <= pick_mask;
            rmw      <= req_we_i[pick] & ~(&pick_mask);
            phase2   <= 1'b0;
`endif
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (drprdy_i) begin
            err <= 1'b0;
`ifdef GT_DRP_RMW_EN
            // The write half of an RMW keeps the old value it read.
            if (!phase2) cap_data <= drpdo_i;
`else
            cap_data <= drpdo_i;
`endif
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            cap_data <= '0;
          end
        end
`ifdef GT_DRP_RMW_EN
        MERGE: begin
          di_lat <= (cap_data & ~mask_lat) | (di_lat & mask_lat);
          phase2 <= 1'b1;
        end
`endif
        RESP:    rr_ptr <= rr_next;
        default: ;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign drpen_o     = (state == ISSUE);
  assign drpaddr_o   = addr_lat;
  assign drpdi_o     = di_lat;
  assign rsp_valid_o = (state == RESP) ? gnt_oh : '0;
  assign rsp_rdata_o = (state == RESP) ? cap_data : '0;
  assign rsp_err_o   = (state == RESP) & err;

`ifdef GT_DRP_RMW_EN
  assign drpwe_o     = drpen_o & we_lat & ~rmw_rd;
  assign req_ready_o = (state == ISSUE && !phase2) ? gnt_oh : '0;
`else
  assign drpwe_o     = drpen_o & we_lat;
  assign req_ready_o = (state == ISSUE) ? gnt_oh : '0;
`endif

endmodule

// File: tb/tb_gt_drp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_gt_drp_arbiter
//
// Bench for gt_drp_arbiter (default build). A transaction-level reference
// model tracks the in-flight DRP access by its age since drpen_o and predicts
// every output each cycle; directed scenarios pin the model with literal
// expectations, then a randomized phase exercises contention, withdrawals,
// spurious ready pulses and timeouts.
// ----------------------------------------------------------------------------
module tb_gt_drp_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int TO = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic            drpen;
  logic            drpwe;
  logic [AW-1:0]   drpaddr;
  logic [DW-1:0]   drpdi;
  logic [DW-1:0]   drpdo = '0;
  logic            drprdy = 1'b0;

  always #5 clk = ~clk;

  gt_drp_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_n_i(rst_n),
    .req_valid_i(req_valid),
    .req_we_i(req_we),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .busy_o(busy),
    .drpen_o(drpen),
    .drpwe_o(drpwe),
    .drpaddr_o(drpaddr),
    .drpdi_o(drpdi),
    .drpdo_i(drpdo),
    .drprdy_i(drprdy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: one transaction record plus its age since drpen.
  bit            m_active;
  bit            m_resp;
  int            m_age;
  int            m_gnt;
  int            m_rr;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_di;
  logic [DW-1:0] m_rdata;
  bit            m_err;

  bit auto_slave = 1'b0;
  bit to_en      = 1'b0;
  int rdy_at     = -1;
  bit pend [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_resp = 0; m_age = 0; m_gnt = 0; m_rr = 0;
    m_we = 0; m_addr = '0; m_di = '0; m_rdata = '0; m_err = 0;
  endtask

  // Advance the model across one clock edge using the inputs of this cycle.
  task automatic model_step();
    bit found;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_resp) begin
      m_resp = 0;
      m_rr   = (m_gnt + 1) % N;
    end else if (m_active) begin
      if (m_age >= 1 && drprdy) begin
        m_active = 0; m_resp = 1; m_rdata = drpdo; m_err = 0;
      end else if (m_age >= TO) begin
        m_active = 0; m_resp = 1; m_rdata = '0; m_err = 1;
      end else begin
        m_age++;
      end
    end else begin
      found = 0;
      for (int o = 0; o < N; o++) begin
        int j;
        j = (m_rr + o) % N;
        if (!found && req_valid[j]) begin
          found    = 1;
          m_gnt    = j;
          m_we     = req_we[j];
          m_addr   = req_addr[j*AW +: AW];
          m_di     = req_wdata[j*DW +: DW];
          m_active = 1;
          m_age    = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit e_en;
    e_en = m_active && (m_age == 0);
    chk("drpen",     32'(drpen),     32'(e_en));
    chk("drpwe",     32'(drpwe),     32'(e_en & m_we));
    chk("req_ready", 32'(req_ready), e_en ? (32'd1 << m_gnt) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), m_resp ? (32'd1 << m_gnt) : 32'd0);
    chk("busy",      32'(busy),      32'(m_active | m_resp));
    chk("drpaddr",   32'(drpaddr),   32'(m_addr));
    chk("drpdi",     32'(drpdi),     32'(m_di));
    if (m_resp) begin
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      chk("rsp_err",   32'(rsp_err),   32'(m_err));
    end
  endtask

  // DRP slave: answers each drpen after 1..5 cycles, occasionally never,
  // and throws stray ready pulses whenever nothing is waiting for one.
  task automatic drive_slave();
    if (drpen) rdy_at = (to_en && ($urandom % 25 == 0)) ? -1 : cyc + int'($urandom_range(1, 5));
    drprdy = (cyc == rdy_at) || ((!busy || drpen || rsp_valid != '0) && ($urandom % 6 == 0));
    drpdo  = DW'($urandom);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) pend[i] = 0;
      if (pend[i] && ($urandom % 50 == 0)) begin
        pend[i] = 0;
      end else if (!pend[i] && ($urandom % 3 == 0)) begin
        pend[i]             = 1;
        req_we[i]           = 1'($urandom);
        req_addr[i*AW +: AW]  = AW'($urandom);
        req_wdata[i*DW +: DW] = DW'($urandom);
      end
      req_valid[i] = pend[i];
    end
  endtask

  // Entered and left at a falling edge.
  task automatic step();
    if (auto_slave) drive_slave();
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv",  32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_err",   32'(rsp_err),   32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_drpen", 32'(drpen),     32'd0);
    chk("rst_drpwe", 32'(drpwe),     32'd0);
    chk("rst_addr",  32'(drpaddr),   32'd0);
    chk("rst_di",    32'(drpdi),     32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_issue(input string name);
    int n;
    n = 0;
    while (!drpen && n < 20) begin
      step();
      n++;
    end
    if (!drpen) chk(name, 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    n = 0;
    while ((busy || n < 2) && n < 600) begin
      step();
      n++;
    end
    if (busy) chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    int got;
    int order [5];
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    model_reset();
    @(negedge clk);
    do_reset();

    // Single read by requester 0, ready three cycles after drpen.
    auto_slave = 0;
    drprdy     = 0;
    req_valid  = 4'b0001;
    req_we     = '0;
    req_addr[0 +: AW] = 9'h011;
    step();
    chk("rd_drpen", 32'(drpen),     32'd1);
    chk("rd_addr",  32'(drpaddr),   32'h011);
    chk("rd_we",    32'(drpwe),     32'd0);
    chk("rd_ready", 32'(req_ready), 32'b0001);
    req_valid = '0;
    step();
    step();
    step();
    drprdy = 1; drpdo = 16'hBEEF;
    step();
    chk("rd_rspv",  32'(rsp_valid), 32'b0001);
    chk("rd_rdata", 32'(rsp_rdata), 32'hBEEF);
    chk("rd_err",   32'(rsp_err),   32'd0);
    drprdy = 0; drpdo = '0;
    step();

    // Stray ready pulses while idle produce nothing.
    for (int i = 0; i < 3; i++) begin
      drprdy = 1;
      drpdo  = 16'h1111;
      step();
      chk("spur_rspv", 32'(rsp_valid), 32'd0);
      chk("spur_busy", 32'(busy),      32'd0);
    end
    drprdy = 0;

    // Round robin with every requester writing continuously.
    do_reset();
    req_valid = '1;
    req_we    = '1;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = AW'(i);
      req_wdata[i*DW +: DW] = DW'(16'hA000 + i);
    end
    auto_slave = 1;
    to_en      = 0;
    got = 0;
    t   = 0;
    while (got < 5 && t < 200) begin
      step();
      t++;
      if (req_ready != '0) begin
        for (int b = 0; b < N; b++) if (req_ready[b]) order[got] = b;
        chk("rr_addr", 32'(drpaddr), 32'(order[got]));
        got++;
      end
    end
    chk("rr_grants", 32'(got), 32'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
    drain();

    // Timeout on requester 2, then a normal read by requester 1.
    auto_slave = 0;
    drprdy     = 0;
    req_valid  = 4'b0100;
    req_we     = '0;
    req_addr[2*AW +: AW] = 9'h0AA;
    wait_issue("to_issue");
    req_valid = '0;
    t = 0;
    while (rsp_valid == '0 && t < 400) begin
      step();
      t++;
    end
    chk("to_latency", 32'(t),         32'd257);
    chk("to_rspv",    32'(rsp_valid), 32'b0100);
    chk("to_err",     32'(rsp_err),   32'd1);
    chk("to_rdata",   32'(rsp_rdata), 32'd0);
    step();
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 9'h1F0;
    wait_issue("after_to_issue");
    req_valid = '0;
    step();
    drprdy = 1; drpdo = 16'h5A5A;
    step();
    chk("after_to_rspv",  32'(rsp_valid), 32'b0010);
    chk("after_to_rdata", 32'(rsp_rdata), 32'h5A5A);
    chk("after_to_err",   32'(rsp_err),   32'd0);
    drprdy = 0;
    step();

    // Ready arriving on the very last timeout cycle wins.
    req_valid = 4'b1000;
    wait_issue("co_issue");
    req_valid = '0;
    for (int a = 0; a < TO; a++) step();
    drprdy = 1; drpdo = 16'hC0DE;
    step();
    chk("co_rspv",  32'(rsp_valid), 32'b1000);
    chk("co_err",   32'(rsp_err),   32'd0);
    chk("co_rdata", 32'(rsp_rdata), 32'hC0DE);
    drprdy = 0;
    step();

    // Reset two cycles after drpen aborts the access silently.
    do_reset();
    req_valid = 4'b0011;
    req_we    = '0;
    step();
    chk("mid_ready0", 32'(req_ready), 32'b0001);
    req_valid = 4'b0010;
    step();
    step();
    do_reset();
    step();
    chk("mid_ready1", 32'(req_ready), 32'b0010);
    chk("mid_rspv",   32'(rsp_valid), 32'd0);
    auto_slave = 1;
    drain();

    // Randomized traffic with withdrawals, stray ready pulses and timeouts.
    to_en = 1;
    for (int i = 0; i < 4000; i++) begin
      drive_reqs();
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
